pinv_seq_ctrl: RTL and testbench

Sequencing controller for the fixed-latency 4x3 Jacobian pseudo-inverse datapath, (JᵀJ)⁻¹Jᵀ built from the float32 mul/adder/div units. The datapath has no usable valid strobe. This block therefore:
- accepts a Jacobian through a valid/ready handshake;
- holds it stable on the datapath inputs;
- counts the datapath latency;
- captures the 12-element result and presents it through a valid/ready output handshake.

It sits between the Newton-Raphson iteration control and the pseudo-inverse datapath.

---
 rtl/pinv_pkg.sv | 29 ++
 rtl/pinv_exp_check.sv | 21 ++
 rtl/pinv_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_pinv_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pinv_pkg.sv
// Shared definitions for the pseudo-inverse sequencing controller:
// state encodings, float32 field positions and an exponent helper.
package pinv_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int FP_W      = 32;
    localparam int N_ELEM    = 12;
    localparam int FP_EXP_HI = 30;
    localparam int FP_EXP_LO = 23;
    localparam int FP_EXP_W  = FP_EXP_HI - FP_EXP_LO + 1;
    localparam int VEC_W     = FP_W * N_ELEM;

    localparam logic [FP_W-1:0] FP_ONE = 32'h3f800000;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_WAIT = S_WAIT,
        ST_DONE = S_DONE
    } state_e;

    // Inf and NaN both carry an all-ones exponent field.
    function automatic logic exp_all_ones(input logic [FP_W-1:0] f);
        return (f[FP_EXP_HI:FP_EXP_LO] == {FP_EXP_W{1'b1}});
    endfunction

endpackage

// File: rtl/pinv_exp_check.sv
// Combinational all-ones exponent detector over the 12 packed float32 results.
// Only instantiated when PINV_NAN_CHECK_EN is defined.
module pinv_exp_check
    import pinv_pkg::*;
(
    input  logic [VEC_W-1:0]  i_res,
    output logic [N_ELEM-1:0] o_flags
);

    // Mantissa and sign bits are intentionally ignored.
    logic w_unused;
    assign w_unused = ^i_res;

    genvar g;
    generate
        for (g = 0; g < N_ELEM; g++) begin : g_elem
            assign o_flags[g] = exp_all_ones(i_res[g*FP_W +: FP_W]);
        end
    endgenerate

endmodule

// File: rtl/pinv_seq_ctrl.sv
// Sequencer for the fixed-latency 4x3 pseudo-inverse datapath: latches a Jacobian,
// counts the datapath latency and captures the result. Optional: PINV_NAN_CHECK_EN.
module pinv_seq_ctrl
    import pinv_pkg::*;
#(
    parameter int LATENCY = 40,
    parameter int CNT_W   = 8
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [VEC_W-1:0]   j_in,
    input  logic               abort,
    output logic [VEC_W-1:0]   dp_j,
    input  logic [VEC_W-1:0]   dp_res,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [VEC_W-1:0]   inv_out,
    output logic [N_ELEM-1:0]  nan_mask,
    output logic               busy
);

    localparam int              LAT_EFF  = (LATENCY < 1) ? 1 : LATENCY;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_EFF);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [VEC_W-1:0]   r_dp_j;
    logic [VEC_W-1:0]   r_inv_out;
    logic               w_accept;
    logic               w_capture;

    assign w_accept  = (r_state == ST_IDLE) && in_valid;
    // Abort wins over the capture that would otherwise happen on the same edge.
    assign w_capture = (r_state == ST_WAIT) && !abort && (r_cnt == CNT_ONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) w_state_nxt = ST_WAIT;
                else          w_state_nxt = ST_IDLE;
            end
            ST_WAIT: begin
                if (abort)                 w_state_nxt = ST_IDLE;
                else if (r_cnt == CNT_ONE) w_state_nxt = ST_DONE;
                else                       w_state_nxt = ST_WAIT;
            end
            ST_DONE: begin
                if (abort || out_ready) w_state_nxt = ST_IDLE;
                else                    w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);

    // Input hold register and latency countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dp_j <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_dp_j <= j_in;
            r_cnt  <= CNT_LOAD;
        end else if (r_state == ST_WAIT) begin
            if (abort) r_cnt <= '0;
            else       r_cnt <= r_cnt - CNT_ONE;
        end else begin
            r_dp_j <= r_dp_j;
            r_cnt  <= r_cnt;
        end
    end

    // Result capture; an aborted job leaves the previous result in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inv_out <= '0;
        end else if (w_capture) begin
            r_inv_out <= dp_res;
        end else begin
            r_inv_out <= r_inv_out;
        end
    end

    assign dp_j    = r_dp_j;
    assign inv_out = r_inv_out;

`ifdef PINV_NAN_CHECK_EN
    logic [N_ELEM-1:0] w_nan_flags;
    logic [N_ELEM-1:0] r_nan_mask;

    pinv_exp_check u_exp_check (
        .i_res   (dp_res),
        .o_flags (w_nan_flags)
    );

    // Exponent flags are latched together with the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nan_mask <= '0;
        end else if (w_capture) begin
            r_nan_mask <= w_nan_flags;
        end else begin
            r_nan_mask <= r_nan_mask;
        end
    end

    assign nan_mask = r_nan_mask;
`else
    assign nan_mask = {N_ELEM{1'b0}};
`endif

endmodule

// File: tb/tb_pinv_seq_ctrl.sv
// Bench for pinv_seq_ctrl: table of jobs plus abort/reset sequences, with a
// delay-line datapath stub (fp_delay_stub) and an expected-result queue.
module tb_pinv_seq_ctrl;
    import pinv_pkg::*;

    localparam int L = 5;
`ifdef PINV_NAN_CHECK_EN
    localparam logic [N_ELEM-1:0] NAN_EXP = 12'h084;
`else
    localparam logic [N_ELEM-1:0] NAN_EXP = 12'h000;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [VEC_W-1:0]   j_in = '0;
    logic               abort = 1'b0;
    logic [VEC_W-1:0]   dp_j;
    logic [VEC_W-1:0]   dp_res;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [VEC_W-1:0]   inv_out;
    logic [N_ELEM-1:0]  nan_mask;
    logic               busy;

    bit                 force_nan = 1'b0;
    int                 edge_no = 0;
    int                 k_edge = 0;
    int                 n_cmp = 0;
    int                 n_bad = 0;
    logic [VEC_W-1:0]   exp_q[$];

    pinv_seq_ctrl #(.LATENCY(L), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .j_in(j_in), .abort(abort), .dp_j(dp_j), .dp_res(dp_res),
        .out_valid(out_valid), .out_ready(out_ready), .inv_out(inv_out),
        .nan_mask(nan_mask), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_no <= edge_no + 1;

    function automatic logic [VEC_W-1:0] make_j(input logic [31:0] j0);
        logic [VEC_W-1:0] v;
        for (int n = 0; n < N_ELEM; n++) v[n*FP_W +: FP_W] = j0 + 32'(n);
        return v;
    endfunction

    function automatic logic [VEC_W-1:0] patch(input logic [VEC_W-1:0] v, input bit f);
        logic [VEC_W-1:0] r;
        r = v;
        if (f) begin
            r[7*FP_W +: FP_W] = 32'h7fc00000;
            r[2*FP_W +: FP_W] = 32'h7f800000;
        end
        return r;
    endfunction

    // fp_delay_stub: the datapath result follows dp_j after L clock edges.
    logic [VEC_W-1:0] pipe [0:L-2];
    always @(posedge clk) begin
        pipe[0] <= dp_j;
        for (int i = 1; i < L-1; i++) pipe[i] <= pipe[i-1];
    end
    assign dp_res = patch(pipe[L-2], force_nan);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic start_job(input logic [VEC_W-1:0] j, input bit expect_done);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin tick(); t++; end
        chk("in_ready_before", in_ready, 1);
        in_valid = 1'b1;
        j_in = j;
        if (expect_done) exp_q.push_back(patch(j, force_nan));
        tick();
        in_valid = 1'b0;
        j_in = '0;
        k_edge = edge_no;
        chk("accept_in_ready", in_ready, 0);
        chk("accept_busy", busy, 1);
        chk("accept_dp_j", dp_j, j);
    endtask

    task automatic finish_wait(input logic [VEC_W-1:0] j, input bit poke);
        int early, rdy, moved;
        early = 0; rdy = 0; moved = 0;
        for (int c = 1; c < L; c++) begin
            if (poke) begin
                in_valid = 1'b1;
                j_in = make_j(32'h40000000);
            end
            tick();
            early += int'(out_valid);
            rdy   += int'(in_ready);
            moved += int'(dp_j !== j);
        end
        in_valid = 1'b0;
        j_in = '0;
        tick();
        chk("wait_out_valid_early", early, 0);
        chk("wait_in_ready", rdy + int'(in_ready), 0);
        chk("wait_dp_j_held", moved + int'(dp_j !== j), 0);
        chk("done_out_valid", out_valid, 1);
        chk("done_latency", edge_no - k_edge, L);
    endtask

    task automatic drain(input int bp, input logic [N_ELEM-1:0] exp_mask);
        logic [VEC_W-1:0] snap, exp;
        int bad;
        snap = inv_out;
        bad = 0;
        for (int c = 0; c < bp; c++) begin
            tick();
            bad += int'(!out_valid || in_ready || (inv_out !== snap));
        end
        chk("backpressure_stable", bad, 0);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            exp = exp_q.pop_front();
            chk("result", inv_out, exp);
        end
        chk("nan_mask", nan_mask, exp_mask);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release_out_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        chk("release_busy", busy, 0);
    endtask

    typedef struct {
        logic [31:0] j0;
        int          bp;
        bit          poke;
        bit          fn;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VEC_W-1:0] prev, ja;
        int ov;

        vecs[0] = '{j0: FP_ONE,       bp: 0,  poke: 1'b0, fn: 1'b0};
        vecs[1] = '{j0: 32'h40400000, bp: 20, poke: 1'b0, fn: 1'b0};
        vecs[2] = '{j0: 32'h41200000, bp: 2,  poke: 1'b1, fn: 1'b0};
        vecs[3] = '{j0: 32'hbf800000, bp: 1,  poke: 1'b0, fn: 1'b1};
        vecs[4] = '{j0: 32'h3e000000, bp: 0,  poke: 1'b0, fn: 1'b0};

        repeat (3) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dp_j", dp_j, '0);
        chk("rst_inv_out", inv_out, '0);
        chk("rst_nan_mask", nan_mask, '0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", in_ready, 1);
        while (edge_no < 9) tick();

        for (int v = 0; v < 5; v++) begin
            force_nan = vecs[v].fn;
            start_job(make_j(vecs[v].j0), 1'b1);
            finish_wait(make_j(vecs[v].j0), vecs[v].poke);
            drain(vecs[v].bp, vecs[v].fn ? NAN_EXP : 12'h000);
            force_nan = 1'b0;
        end

        // Abort while cnt==3: no capture, previous result kept.
        prev = inv_out;
        start_job(make_j(32'h42000000), 1'b0);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_wait_out_valid", out_valid, 0);
        chk("abort_wait_in_ready", in_ready, 1);
        ov = 0;
        for (int c = 0; c < L + 2; c++) begin tick(); ov += int'(out_valid); end
        chk("abort_wait_no_done", ov, 0);
        chk("abort_wait_inv_kept", inv_out, prev);

        // Abort together with out_ready in DONE.
        ja = make_j(32'h42800000);
        start_job(ja, 1'b1);
        finish_wait(ja, 1'b0);
        chk("abort_done_result", inv_out, exp_q.pop_front());
        abort = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("abort_done_out_valid", out_valid, 0);
        chk("abort_done_in_ready", in_ready, 1);
        chk("abort_done_inv_kept", inv_out, ja);

        // Abort in IDLE does not block a simultaneous accept.
        ja = make_j(32'h43000000);
        in_valid = 1'b1;
        j_in = ja;
        exp_q.push_back(ja);
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        j_in = '0;
        k_edge = edge_no;
        chk("abort_idle_accepted", in_ready, 0);
        chk("abort_idle_dp_j", dp_j, ja);
        finish_wait(ja, 1'b0);
        drain(0, 12'h000);

        // Asynchronous reset between edges in the middle of WAIT.
        start_job(make_j(32'h43800000), 1'b0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_out_valid", out_valid, 0);
        chk("rst_async_dp_j", dp_j, '0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_inv_out", inv_out, '0);
        repeat (L) tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        ja = make_j(32'h44000000);
        start_job(ja, 1'b1);
        finish_wait(ja, 1'b0);
        drain(3, 12'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
